// File: rtl/arb_pkg.sv
// Shared helpers for the round-robin lock arbiter: index-width rule
// and the chosen-index type for the default 4-channel configuration.
package arb_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < n; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Index width never drops below one bit, so N=1 still has a port.
    function automatic int unsigned cw_of(input int unsigned n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned CW_DEF = cw_of(N_DEF);

    typedef logic [CW_DEF-1:0] chosen_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first requester after ptr_i, modulo N.
// Ports: req_i (N requests), ptr_i (last grant), idx_o (winner), any_o.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = cw_of(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [CW-1:0] ptr_i,
    output logic [CW-1:0] idx_o,
    output logic          any_o
);

    logic [CW-1:0] c;

    // Walk the ring from farthest to nearest so the nearest request
    // after ptr_i is the last assignment and therefore wins.
    always_comb begin
        idx_o = '0;
        c     = '0;
        for (int k = N; k >= 1; k--) begin
            c = CW'((int'(ptr_i) + k) % N);
            if (req_i[c]) begin
                idx_o = c;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with packet locking and a registered output.
// Ports: io_in_* (N ready/valid beat channels), io_out_* (merged channel),
//        io_chosen (source of the registered beat), clk, reset_n.
module rr_lock_arbiter
    import arb_pkg::*;
#(
    parameter  int unsigned N  = 4,
    parameter  int unsigned W  = 8,
    localparam int unsigned CW = cw_of(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    io_in_valid,
    input  logic [N*W-1:0]  io_in_bits,
    input  logic [N-1:0]    io_in_last,
    output logic [N-1:0]    io_in_ready,
    output logic            io_out_valid,
    output logic [W-1:0]    io_out_bits,
    output logic            io_out_last,
    input  logic            io_out_ready,
    output logic [CW-1:0]   io_chosen
);

    logic [CW-1:0] ptr_q, ptr_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] lock_idx_q, lock_idx_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_bits_q, out_bits_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] chosen_q, chosen_d;

    logic [CW-1:0] pick_idx;
    logic          pick_any;
    logic [CW-1:0] sel;
    logic [W-1:0]  sel_bits;
    logic          sel_last;
    logic          sel_vld;
    logic          sel_valid;
    logic          load;
    logic          grant;
    logic          fire;

    rr_pick #(.N(N)) u_pick (
        .req_i (io_in_valid),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        sel      = locked_q ? lock_idx_q : pick_idx;
        sel_bits = '0;
        sel_last = 1'b0;
        sel_vld  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == sel) begin
                sel_bits = io_in_bits[i*W +: W];
                sel_last = io_in_last[i];
                sel_vld  = io_in_valid[i];
            end
        end
        // A locked packet stalls the arbiter rather than yield mid-packet.
        sel_valid = locked_q ? sel_vld : pick_any;
        load      = !out_valid_q || io_out_ready;
        // No channel is handed a ready while reset is held.
        grant     = reset_n && load && sel_valid;
        fire      = grant && sel_vld;
        for (int i = 0; i < N; i++) begin
            io_in_ready[i] = grant && (CW'(i) == sel);
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        locked_d    = locked_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_bits_d  = out_bits_q;
        out_last_d  = out_last_q;
        chosen_d    = chosen_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_bits_d  = sel_bits;
            out_last_d  = sel_last;
            chosen_d    = sel;
            if (sel_last) begin
                locked_d = 1'b0;
                ptr_d    = sel;
            end else begin
                locked_d   = 1'b1;
                lock_idx_d = sel;
            end
        end else if (io_out_ready && out_valid_q) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= CW'(N - 1);
            locked_q    <= 1'b0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_bits_q  <= '0;
            out_last_q  <= 1'b0;
            chosen_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            locked_q    <= locked_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_bits_q  <= out_bits_d;
            out_last_q  <= out_last_d;
            chosen_q    <= chosen_d;
        end
    end

    assign io_out_valid = out_valid_q;
    assign io_out_bits  = out_bits_q;
    assign io_out_last  = out_last_q;
    assign io_chosen    = chosen_q;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter: a 4x8 instance and a 3x16 instance.
// Ports exercised: all io_* channels, clk and reset_n of both instances.
module tb_rr_lock_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  v;
    logic [31:0] bits;
    logic [3:0]  last;
    logic [3:0]  rdy;
    logic        ovld;
    logic [7:0]  obits;
    logic        olast;
    logic        ordy;
    logic [1:0]  chosen;

    logic        rst3;
    logic [2:0]  v3;
    logic [47:0] bits3;
    logic [2:0]  last3;
    logic [2:0]  rdy3;
    logic        ovld3;
    logic [15:0] obits3;
    logic        olast3;
    logic        ordy3;
    logic [1:0]  chosen3;

    int errors;
    int checks;

    rr_lock_arbiter #(.N(4), .W(8)) u_dut (
        .clk          (clk),
        .reset_n      (rst),
        .io_in_valid  (v),
        .io_in_bits   (bits),
        .io_in_last   (last),
        .io_in_ready  (rdy),
        .io_out_valid (ovld),
        .io_out_bits  (obits),
        .io_out_last  (olast),
        .io_out_ready (ordy),
        .io_chosen    (chosen)
    );

    rr_lock_arbiter #(.N(3), .W(16)) u_dut3 (
        .clk          (clk),
        .reset_n      (rst3),
        .io_in_valid  (v3),
        .io_in_bits   (bits3),
        .io_in_last   (last3),
        .io_in_ready  (rdy3),
        .io_out_valid (ovld3),
        .io_out_bits  (obits3),
        .io_out_last  (olast3),
        .io_out_ready (ordy3),
        .io_chosen    (chosen3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        v      = 4'hF;
        bits   = 32'h33221100;
        last   = 4'hF;
        ordy   = 1'b1;
        rst3   = 1'b0;
        v3     = 3'b111;
        bits3  = 48'h2222_1111_0A0A;
        last3  = 3'b111;
        ordy3  = 1'b1;
        tick;
        tick;

        // T1: reset held with every channel valid
        chk("t1_ovld", 32'(ovld), 0);
        chk("t1_obits", 32'(obits), 0);
        chk("t1_olast", 32'(olast), 0);
        chk("t1_chosen", 32'(chosen), 0);
        chk("t1_rdy", 32'(rdy), 0);
        chk("t1_rdy3", 32'(rdy3), 0);
        chk("t1_ovld3", 32'(ovld3), 0);
        v3  = 3'b000;
        rst = 1'b1;
        #1;
        chk("t1_rdy_rel", 32'(rdy), 32'b0001);

        // T2: fairness, single-beat packets, ring order from channel 0
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_rdy", 32'(rdy), 32'(1 << (i % 4)));
            tick;
            chk("t2_chosen", 32'(chosen), 32'(i % 4));
            chk("t2_bits", 32'(obits), 32'(8'h11 * (i % 4)));
            chk("t2_ovld", 32'(ovld), 1);
        end

        // T3: ch1 3-beat packet locks out ch0/ch2; ch3 idle is skipped
        v = 4'b0111;
        for (int b = 1; b <= 3; b++) begin
            bits[15:8] = 8'(8'hB0 + b);
            last       = (b == 3) ? 4'b1111 : 4'b1101;
            #1;
            chk("t3_rdy", 32'(rdy), 32'b0010);
            tick;
            chk("t3_chosen", 32'(chosen), 1);
            chk("t3_bits", 32'(obits), 32'(8'hB0 + b));
            chk("t3_last", 32'(olast), (b == 3) ? 1 : 0);
        end
        #1;
        chk("t3_rdy_ch2", 32'(rdy), 32'b0100);
        tick;
        chk("t3_chosen_ch2", 32'(chosen), 2);
        #1;
        chk("t3_rdy_ch0", 32'(rdy), 32'b0001);
        tick;
        chk("t3_chosen_ch0", 32'(chosen), 0);

        // T4: backpressure holds beat 0xA5
        v          = 4'b0010;
        bits[15:8] = 8'hA5;
        #1;
        chk("t4_rdy_load", 32'(rdy), 32'b0010);
        tick;
        chk("t4_bits_load", 32'(obits), 32'hA5);
        ordy       = 1'b0;
        bits[15:8] = 8'h5A;
        repeat (5) begin
            #1;
            chk("t4_rdy_stall", 32'(rdy), 0);
            tick;
            chk("t4_bits_hold", 32'(obits), 32'hA5);
            chk("t4_ovld_hold", 32'(ovld), 1);
        end
        ordy = 1'b1;
        v    = 4'b0000;
        #1;
        chk("t4_rdy_drain", 32'(rdy), 0);
        tick;
        chk("t4_ovld_drain", 32'(ovld), 0);
        chk("t4_bits_keep", 32'(obits), 32'hA5);

        // T5: locked ch2 drops valid; ch0 must wait
        v           = 4'b0100;
        bits[23:16] = 8'hC1;
        last        = 4'b1011;
        #1;
        chk("t5_rdy_lock", 32'(rdy), 32'b0100);
        tick;
        chk("t5_chosen_lock", 32'(chosen), 2);
        v = 4'b0001;
        repeat (2) begin
            #1;
            chk("t5_rdy_bubble", 32'(rdy), 0);
            tick;
            chk("t5_ovld_bubble", 32'(ovld), 0);
        end
        v           = 4'b0101;
        bits[23:16] = 8'hC2;
        last        = 4'hF;
        #1;
        chk("t5_rdy_resume", 32'(rdy), 32'b0100);
        tick;
        chk("t5_chosen_resume", 32'(chosen), 2);
        chk("t5_bits_resume", 32'(obits), 32'hC2);
        v = 4'b0001;
        #1;
        chk("t5_rdy_ch0", 32'(rdy), 32'b0001);
        tick;
        chk("t5_chosen_ch0", 32'(chosen), 0);

        // T6: N=3 W=16, async reset in the middle of a ch1 packet
        rst3         = 1'b1;
        v3           = 3'b010;
        last3        = 3'b000;
        bits3[31:16] = 16'h1001;
        #1;
        chk("t6_rdy_b1", 32'(rdy3), 32'b010);
        tick;
        chk("t6_chosen_b1", 32'(chosen3), 1);
        chk("t6_bits_b1", 32'(obits3), 32'h1001);
        v3           = 3'b011;
        bits3[31:16] = 16'h1002;
        #1;
        chk("t6_rdy_b2", 32'(rdy3), 32'b010);
        rst3 = 1'b0;
        #1;
        chk("t6_ovld_rst", 32'(ovld3), 0);
        chk("t6_chosen_rst", 32'(chosen3), 0);
        chk("t6_bits_rst", 32'(obits3), 0);
        chk("t6_rdy_rst", 32'(rdy3), 0);
        tick;
        rst3  = 1'b1;
        last3 = 3'b111;
        #1;
        chk("t6_rdy_after", 32'(rdy3), 32'b001);
        tick;
        chk("t6_chosen_after", 32'(chosen3), 0);
        chk("t6_bits_after", 32'(obits3), 32'h0A0A);
        v3           = 3'b100;
        bits3[47:32] = 16'hBEEF;
        #1;
        chk("t6_rdy_ch2", 32'(rdy3), 32'b100);
        tick;
        chk("t6_chosen_ch2", 32'(chosen3), 2);
        chk("t6_bits_ch2", 32'(obits3), 32'hBEEF);
        v3 = 3'b011;
        #1;
        chk("t6_rdy_wrap", 32'(rdy3), 32'b001);
        tick;
        chk("t6_chosen_wrap", 32'(chosen3), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
